serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Serial byte transmitter sitting directly downstream of the 50 kHz divider in the Sender path.
- Runs on the 20 MHz system clock and uses the divided clock only as a bit-rate reference: its rising edge becomes a one-cycle bit strobe.
- Accepts parallel bytes over a valid/ready handshake and serialises each one as a UART-style frame: start bit, data LSB-first, optional even parity, stop bit(s).

Parameters:
- DATA_BITS, 8: data bits per frame (1..16).
- PARITY_EN, 1: 1 inserts an even-parity bit after the data; 0 omits it.
- STOP_BITS, 1: number of stop-bit periods (1 or 2).

Ports:
- clock_in  input  1  20 MHz system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_clk  input  1  divided 50 kHz clock from the divider; treated as a synchronous data signal in the clock_in domain.
- tx_data  input  DATA_BITS  byte to send; sampled only on accept.
- tx_valid  input  1  producer has data on tx_data.
- tx_ready  output  1  block can accept; accept happens when tx_valid && tx_ready on a clock_in edge.
- tx_out  output  1  serial line output; idle level is 1.
- busy  output  1  frame in progress, from accept until done.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Clocking and reset:
  - One clock (clock_in).
  - Reset is synchronous, active-high.
  - Reset values: tx_out=1, tx_ready=1, busy=0, done=0, state=IDLE, shift register=0, bit counter=0, bit_clk delay register=0.
- Bit strobe:
  - strobe = bit_clk & ~bit_clk_d, where bit_clk_d is bit_clk registered on clock_in.
  - This gives one strobe per 400 clock_in cycles. No synchronizer, because the source is already in the same clock domain.
- State machine (all transitions on clock_in edge):
  - IDLE: tx_ready=1, tx_out=1. On accept: latch tx_data into the shift register, compute parity = ^tx_data, tx_ready->0, busy->1, go to START.
  - START: wait for strobe. On strobe: tx_out<=0, bit counter<=0, go to DATA.
  - DATA: on each strobe: tx_out<=shift[0], shift right, counter++. On the strobe that drives bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: wait for the strobe after the last data bit. On that strobe: tx_out<=parity (even; total ones including parity is even), go to STOP.
  - STOP: on strobe: tx_out<=1, stop counter++. After STOP_BITS stop periods have been driven, the next strobe produces done=1 (one cycle), busy->0, tx_ready->1, go to IDLE.
- Bit timing:
  - Every line bit, including each stop bit, is held for exactly one strobe period.
  - Bit-boundary latency is 1 clock_in cycle after the strobe-generating bit_clk rising edge.
- Boundary conditions:
  - A strobe in the same cycle as accept does not start the frame; the start bit goes out on the first strobe strictly after the accept cycle.
  - Back-to-back frames: with tx_valid held high, the next accept occurs in the cycle after done. Its start bit goes out on the next strobe, so the line shows exactly one extra idle-high period between frames.
  - tx_data/tx_valid changes while busy are ignored; the latched copy is transmitted.
  - bit_clk stuck at either level: the FSM holds its state indefinitely and tx_out holds its level. There is no timeout.
  - Reset asserted mid-frame: on that edge tx_out=1, the frame is discarded, no done pulse, and tx_ready=1 the next cycle.
  - tx_valid asserted during reset is not accepted.

Decomposition:
- Shared package/include holds:
  - state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits);
  - LINE_IDLE=1'b1 and LINE_START=1'b0;
  - default DATA_BITS/STOP_BITS constants, reused by the receiver side.
- One sub-module: bit_strobe_gen (bit_clk in, registered delay, strobe out, synchronous reset). It is reused by any future consumer of the divider output.

Test Plan:
- Reset, then a 400-cycle bit_clk (200 high/200 low) with no tx_valid for 5 periods -> tx_out=1, tx_ready=1, busy=0, done never pulses.
- Send 0xA5 with PARITY_EN=1, STOP_BITS=1 -> one bit per strobe reading 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop); done pulses exactly 1 cycle, 11 strobes after the start strobe (~4400 cycles after start); tx_ready=1 in the next cycle.
- Send 0x07 with PARITY_EN=1 -> parity bit 1. With PARITY_EN=0, STOP_BITS=2 -> 0,1,1,1,0,0,0,0,0,1,1 and done after 11 strobes.
- Hold tx_valid high with 0x55 then 0xAA -> two frames with exactly one extra idle-high bit period between the last stop bit and the second start bit; the second frame data reads 0,1,0,1,0,1,0,1.
- Assert tx_valid in the same cycle a strobe occurs -> start bit appears on the following strobe (400 cycles later), not the current one.
- Assert reset for 1 cycle during data bit 4 -> tx_out=1 on the next edge, no done pulse, tx_ready=1. A new 0x3C frame sent afterwards is bit-exact.

Source files
------------

// File: rtl/serial_frame_tx_pkg.sv
// Shared encodings and defaults for the serial frame transmitter and the matching receiver.
package serial_frame_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;

   localparam int DEF_DATA_BITS = 8;
   localparam int DEF_PARITY_EN = 1;
   localparam int DEF_STOP_BITS = 1;

endpackage

// File: rtl/serial_frame_tx_strobe.sv
// Turns the divider output into a one-cycle strobe on each of its rising edges.
// bit_clk already lives in the clock_in domain, so no synchronizer is needed.
module bit_strobe_gen (
   input  logic clock_in,
   input  logic reset,
   input  logic bit_clk,
   output logic strobe
);

   logic bit_clk_d;

   always_ff @(posedge clock_in) begin
      if (reset) begin
         bit_clk_d <= 1'b0;
      end else begin
         bit_clk_d <= bit_clk;
      end
   end

   assign strobe = bit_clk & ~bit_clk_d;

endmodule

// File: rtl/serial_frame_tx.sv
// UART-style frame transmitter: start, data LSB-first, optional even parity, stop bit(s).
// Each line bit is held for one bit_clk strobe period.
//
// state  | meaning
// IDLE   | line high, ready for a new byte
// START  | byte latched, waiting for strobe to drive the start bit
// DATA   | shifting data bits out, one per strobe
// PARITY | last data bit on the line, next strobe drives parity
// STOP   | driving stop bit(s); strobe after the last one raises done
module serial_frame_tx
   import serial_frame_tx_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int PARITY_EN = DEF_PARITY_EN,
   parameter int STOP_BITS = DEF_STOP_BITS
) (
   input  logic                 clock_in,
   input  logic                 reset,
   input  logic                 bit_clk,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_out,
   output logic                 busy,
   output logic                 done
);

   localparam logic [4:0] LAST_BIT  = 5'(DATA_BITS - 1);
   localparam logic [1:0] STOP_LAST = 2'(STOP_BITS);

   tx_state_t            state_q, state_n;
   logic [DATA_BITS-1:0] shift_q, shift_n;
   logic [4:0]           bit_cnt_q, bit_cnt_n;
   logic [1:0]           stop_cnt_q, stop_cnt_n;
   logic                 parity_q, parity_n;
   logic                 tx_out_q, tx_out_n;
   logic                 done_q, done_n;
   logic                 strobe;

   bit_strobe_gen u_strobe (
      .clock_in (clock_in),
      .reset    (reset),
      .bit_clk  (bit_clk),
      .strobe   (strobe)
   );

   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= '0;
         parity_q   <= 1'b0;
         tx_out_q   <= LINE_IDLE;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_n;
         shift_q    <= shift_n;
         bit_cnt_q  <= bit_cnt_n;
         stop_cnt_q <= stop_cnt_n;
         parity_q   <= parity_n;
         tx_out_q   <= tx_out_n;
         done_q     <= done_n;
      end
   end

   always_comb begin
      state_n    = state_q;
      shift_n    = shift_q;
      bit_cnt_n  = bit_cnt_q;
      stop_cnt_n = stop_cnt_q;
      parity_n   = parity_q;
      tx_out_n   = tx_out_q;
      done_n     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_out_n = LINE_IDLE;
            if (tx_valid) begin
               shift_n  = tx_data;
               parity_n = ^tx_data;
               state_n  = START;
            end
         end
         START: begin
            if (strobe) begin
               tx_out_n   = LINE_START;
               bit_cnt_n  = '0;
               stop_cnt_n = '0;
               state_n    = DATA;
            end
         end
         DATA: begin
            if (strobe) begin
               tx_out_n  = shift_q[0];
               shift_n   = shift_q >> 1;
               bit_cnt_n = bit_cnt_q + 5'd1;
               if (bit_cnt_q == LAST_BIT) begin
                  if (PARITY_EN != 0) begin
                     state_n = PARITY;
                  end else begin
                     state_n = STOP;
                  end
               end
            end
         end
         PARITY: begin
            if (strobe) begin
               tx_out_n = parity_q;
               state_n  = STOP;
            end
         end
         STOP: begin
            // The strobe after the last stop period only closes the frame; the line is already high.
            if (strobe) begin
               if (stop_cnt_q == STOP_LAST) begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  tx_out_n   = LINE_IDLE;
                  stop_cnt_n = stop_cnt_q + 2'd1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign tx_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign tx_out   = tx_out_q;
   assign done     = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: a parity/1-stop instance and a no-parity/2-stop instance.
module tb_serial_frame_tx;

   logic       clock_in;
   logic       reset;
   logic       bit_clk;
   logic [7:0] tx_data1, tx_data2;
   logic       tx_valid1, tx_valid2;
   logic       tx_ready1, tx_ready2;
   logic       tx_out1, tx_out2;
   logic       busy1, busy2;
   logic       done1, done2;

   logic       sel;
   logic       tx_out_m, busy_m, ready_m, done_m;
   logic       bclk_en, bclk_lvl;
   int         ph = 0;
   int         done_cyc1 = 0;
   int         done_cyc2 = 0;
   int         checks = 0;
   int         errors = 0;
   int         base;
   logic       exp_q[$];

   serial_frame_tx dut1 (
      .clock_in (clock_in),
      .reset    (reset),
      .bit_clk  (bit_clk),
      .tx_data  (tx_data1),
      .tx_valid (tx_valid1),
      .tx_ready (tx_ready1),
      .tx_out   (tx_out1),
      .busy     (busy1),
      .done     (done1)
   );

   serial_frame_tx #(.DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
      .clock_in (clock_in),
      .reset    (reset),
      .bit_clk  (bit_clk),
      .tx_data  (tx_data2),
      .tx_valid (tx_valid2),
      .tx_ready (tx_ready2),
      .tx_out   (tx_out2),
      .busy     (busy2),
      .done     (done2)
   );

   initial clock_in = 1'b0;
   always #25 clock_in = ~clock_in;

   // Free-running 400-cycle bit period: high for phases 0..199, low for 200..399.
   always @(posedge clock_in) ph <= (ph == 399) ? 0 : ph + 1;
   assign bit_clk = bclk_en ? (ph < 200) : bclk_lvl;

   always @(negedge clock_in) begin
      if (done1 === 1'b1) done_cyc1++;
      if (done2 === 1'b1) done_cyc2++;
   end

   assign tx_out_m = sel ? tx_out2   : tx_out1;
   assign busy_m   = sel ? busy2     : busy1;
   assign ready_m  = sel ? tx_ready2 : tx_ready1;
   assign done_m   = sel ? done2     : done1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ph(input int p);
      do @(negedge clock_in); while (ph != p);
   endtask

   function automatic int done_cnt();
      return sel ? done_cyc2 : done_cyc1;
   endfunction

   task automatic drive(input logic v, input logic [7:0] d);
      if (sel) begin
         tx_valid2 = v;
         tx_data2  = d;
      end else begin
         tx_valid1 = v;
         tx_data1  = d;
      end
   endtask

   task automatic push_frame(input logic [7:0] d);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
      if (sel) begin
         exp_q.push_back(1'b1);
         exp_q.push_back(1'b1);
      end else begin
         exp_q.push_back(^d);
         exp_q.push_back(1'b1);
      end
   endtask

   task automatic run_bits(input string tag, input int n);
      logic e;
      for (int i = 0; i < n; i++) begin
         wait_ph(200);
         e = exp_q.pop_front();
         chk($sformatf("%s_bit%0d", tag, i), 16'(tx_out_m), 16'(e));
      end
   endtask

   task automatic check_done(input string tag, input int b);
      wait_ph(0);
      @(negedge clock_in);
      chk({tag, "_done"}, 16'(done_m), 16'd1);
      chk({tag, "_busy_end"}, 16'(busy_m), 16'd0);
      chk({tag, "_ready_end"}, 16'(ready_m), 16'd1);
      @(negedge clock_in);
      chk({tag, "_done_fall"}, 16'(done_m), 16'd0);
      chk({tag, "_done_count"}, 16'(done_cnt() - b), 16'd1);
   endtask

   task automatic send_frame(input string tag, input logic [7:0] d);
      int b;
      b = done_cnt();
      wait_ph(100);
      drive(1'b1, d);
      push_frame(d);
      @(negedge clock_in);
      chk({tag, "_busy"}, 16'(busy_m), 16'd1);
      chk({tag, "_ready"}, 16'(ready_m), 16'd0);
      drive(1'b0, ~d);
      wait_ph(0);
      run_bits(tag, 11);
      check_done(tag, b);
   endtask

   initial begin
      reset     = 1'b1;
      sel       = 1'b0;
      bclk_en   = 1'b1;
      bclk_lvl  = 1'b0;
      tx_valid1 = 1'b1;
      tx_data1  = 8'hFF;
      tx_valid2 = 1'b0;
      tx_data2  = 8'h00;
      repeat (5) @(negedge clock_in);
      chk("rst_tx_out", 16'(tx_out1), 16'd1);
      chk("rst_ready", 16'(tx_ready1), 16'd1);
      chk("rst_busy", 16'(busy1), 16'd0);
      chk("rst_done", 16'(done1), 16'd0);
      reset     = 1'b0;
      tx_valid1 = 1'b0;
      @(negedge clock_in);
      chk("rst_valid_ignored", 16'(busy1), 16'd0);

      // Idle line over five bit periods
      for (int i = 0; i < 5; i++) begin
         wait_ph(200);
         chk($sformatf("idle_line%0d", i), 16'(tx_out1), 16'd1);
      end
      chk("idle_ready", 16'(tx_ready1), 16'd1);
      chk("idle_busy", 16'(busy1), 16'd0);
      chk("idle_no_done", 16'(done_cyc1), 16'd0);

      send_frame("a5", 8'hA5);
      send_frame("07_par", 8'h07);
      sel = 1'b1;
      send_frame("07_stop2", 8'h07);
      sel = 1'b0;

      // Back-to-back frames with tx_valid held high
      base = done_cyc1;
      wait_ph(100);
      tx_valid1 = 1'b1;
      tx_data1  = 8'h55;
      push_frame(8'h55);
      @(negedge clock_in);
      tx_data1 = 8'hAA;
      wait_ph(0);
      run_bits("b2b_first", 11);
      wait_ph(0);
      @(negedge clock_in);
      chk("b2b_done1", 16'(done1), 16'd1);
      @(negedge clock_in);
      chk("b2b_reaccept", 16'(busy1), 16'd1);
      tx_valid1 = 1'b0;
      exp_q.push_back(1'b1);
      push_frame(8'hAA);
      run_bits("b2b_second", 12);
      check_done("b2b", base + 1);

      // Accept coincident with a strobe: start bit waits for the next strobe
      base = done_cyc1;
      wait_ph(0);
      tx_valid1 = 1'b1;
      tx_data1  = 8'h96;
      @(negedge clock_in);
      tx_valid1 = 1'b0;
      chk("same_strobe_busy", 16'(busy1), 16'd1);
      exp_q.push_back(1'b1);
      push_frame(8'h96);
      run_bits("same_strobe", 12);
      check_done("same_strobe", base);

      // Reset during data bit 4
      base = done_cyc1;
      wait_ph(100);
      tx_valid1 = 1'b1;
      tx_data1  = 8'h00;
      push_frame(8'h00);
      @(negedge clock_in);
      tx_valid1 = 1'b0;
      wait_ph(0);
      run_bits("rst_mid_pre", 5);
      wait_ph(200);
      chk("rst_mid_bit4", 16'(tx_out1), 16'd0);
      reset = 1'b1;
      @(negedge clock_in);
      reset = 1'b0;
      exp_q.delete();
      chk("rst_mid_tx_out", 16'(tx_out1), 16'd1);
      chk("rst_mid_ready", 16'(tx_ready1), 16'd1);
      chk("rst_mid_busy", 16'(busy1), 16'd0);
      chk("rst_mid_done", 16'(done1), 16'd0);
      for (int i = 0; i < 12; i++) wait_ph(200);
      chk("rst_mid_no_done", 16'(done_cyc1 - base), 16'd0);
      chk("rst_mid_line", 16'(tx_out1), 16'd1);
      send_frame("3c", 8'h3C);

      // bit_clk stuck low, then stuck high
      wait_ph(100);
      tx_valid1 = 1'b1;
      tx_data1  = 8'h0F;
      @(negedge clock_in);
      tx_valid1 = 1'b0;
      wait_ph(0);
      wait_ph(200);
      chk("stuck_start", 16'(tx_out1), 16'd0);
      bclk_lvl = 1'b0;
      bclk_en  = 1'b0;
      repeat (1000) @(negedge clock_in);
      chk("stuck_low_line", 16'(tx_out1), 16'd0);
      chk("stuck_low_busy", 16'(busy1), 16'd1);
      bclk_lvl = 1'b1;
      repeat (1000) @(negedge clock_in);
      chk("stuck_high_line", 16'(tx_out1), 16'd1);
      chk("stuck_high_busy", 16'(busy1), 16'd1);
      chk("stuck_no_done", 16'(done1), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
